ha_array_reducer: RTL



---
 rtl/ha_array_reducer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ha_array_reducer.sv
// rtl/ha_array_reducer.sv - sequential final-stage reducer for the 8x8 approximate multiplier HA array
//
// Purpose:
//   Captures the four row pairs produced by the half-adder array generator,
//   weights each row by 4^k and accumulates them into a 17-bit accumulator.
//   Rows are added one per cycle by default, or two per cycle when
//   HA_REDUCER_DUAL_ROW_EN is defined. The 16-bit product and an overflow
//   flag are then offered on a valid/ready output port.
//
// Configuration macro:
//   HA_REDUCER_DUAL_ROW_EN  defined   : two rows per ACC cycle, 2-cycle latency
//                           undefined : one row per ACC cycle, 4-cycle latency
//
// Ports:
//   clk                         rising-edge clock
//   rst_n                       asynchronous active-low reset
//   in_valid / in_ready         row-set handshake
//   ha_array_k_b (k=0..3) [6:0] carry rows, bit j weighs 2^(j+2) within row k
//   ha_array_k_t (k=0..3) [8:0] sum rows,   bit j weighs 2^j within row k
//   out_valid / out_ready       result handshake
//   out_product [15:0]          accumulator bits [15:0]
//   out_ovf                     accumulator bit 16

module ha_array_reducer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [8:0]  t_q [4];
  logic [6:0]  b_q [4];
  logic [16:0] acc;
  logic [1:0]  row_cnt;

  logic [9:0]  row_val [4];
  logic [16:0] add_val;
  logic [16:0] acc_sum;
  logic [1:0]  row_step;
  logic        last_step;
  logic        accept;

  // Collapse each redundant row pair into its binary value R_k = t_k + 4*b_k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      row_val[k] = {1'b0, t_q[k]} + {1'b0, b_q[k], 2'b00};
    end
  end

`ifdef HA_REDUCER_DUAL_ROW_EN
  // Rows row_cnt and row_cnt+1 are folded in together; row_cnt is 0 or 2.
  always_comb begin
    add_val   = ({7'd0, row_val[row_cnt]} << {row_cnt, 1'b0})
              + ({7'd0, row_val[row_cnt + 2'd1]} << ({row_cnt, 1'b0} + 3'd2));
    row_step  = 2'd2;
    last_step = (row_cnt == 2'd2);
  end
`else
  always_comb begin
    add_val   = {7'd0, row_val[row_cnt]} << {row_cnt, 1'b0};
    row_step  = 2'd1;
    last_step = (row_cnt == 2'd3);
  end
`endif

  // Largest possible total is 85 * 1019 = 86615, so 17 bits never wrap.
  assign acc_sum = acc + add_val;
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The result registers are separate from acc so the last result
  // stays visible while the next row set is being accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        t_q[k] <= 9'd0;
        b_q[k] <= 7'd0;
      end
      acc         <= 17'd0;
      row_cnt     <= 2'd0;
      out_product <= 16'd0;
      out_ovf     <= 1'b0;
    end else if (accept) begin
      t_q[0]  <= ha_array_0_t;
      t_q[1]  <= ha_array_1_t;
      t_q[2]  <= ha_array_2_t;
      t_q[3]  <= ha_array_3_t;
      b_q[0]  <= ha_array_0_b;
      b_q[1]  <= ha_array_1_b;
      b_q[2]  <= ha_array_2_b;
      b_q[3]  <= ha_array_3_b;
      acc     <= 17'd0;
      row_cnt <= 2'd0;
    end else if (state == ACC) begin
      acc     <= acc_sum;
      row_cnt <= row_cnt + row_step;
      if (last_step) begin
        out_product <= acc_sum[15:0];
        out_ovf     <= acc_sum[16];
      end
    end
  end

endmodule
